transfer_ctrl: RTL and testbench

TRANSFER_CTRL -- requirements
Module: transfer_ctrl

---
 rtl/transfer_ctrl.sv | 118 +++++++++++
 tb/tb_transfer_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/transfer_ctrl.sv
// Transfer controller: configuration/idle/active/error sequencing with
// per-port hysteretic backpressure and sticky FIFO error capture.
module transfer_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic [2:0]  Umbral_bajo,
    input  logic [2:0]  Umbral_alto,
    input  logic [4:0]  fifo_empty,
    input  logic [4:0]  fifo_error,
    input  logic [15:0] occ,
    output logic [2:0]  state,
    output logic        idle_out,
    output logic        active_out,
    output logic        error_out,
    output logic [2:0]  umbral_bajo_q,
    output logic [2:0]  umbral_alto_q,
    output logic [3:0]  pause,
    output logic [4:0]  error_code
);
    // state  | meaning
    // RESET  | held in reset, next cycle enters INIT
    // INIT   | latching thresholds until init=0 and alto > bajo
    // IDLE   | all FIFOs empty
    // ACTIVE | at least one FIFO holds data
    // ERROR  | FIFO over/underflow seen; only reset leaves
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] pause_d;
    logic [4:0] error_code_d;
    logic       any_error;

    assign any_error = |fifo_error;
    assign state     = state_q;

    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                if (!init && (Umbral_alto > Umbral_bajo)) state_d = S_IDLE;
                else                                       state_d = S_INIT;
            end
            S_IDLE: begin
                if (any_error)                 state_d = S_ERROR;
                else if (init)                 state_d = S_INIT;
                else if (fifo_empty != 5'h1F)  state_d = S_ACTIVE;
                else                           state_d = S_IDLE;
            end
            S_ACTIVE: begin
                if (any_error)                 state_d = S_ERROR;
                else if (init)                 state_d = S_INIT;
                else if (fifo_empty == 5'h1F)  state_d = S_IDLE;
                else                           state_d = S_ACTIVE;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_RESET;
        endcase
    end

    // Backpressure follows the state being entered; hysteresis only runs
    // while the controller is already operating, so INIT->IDLE starts clear.
    always_comb begin
        pause_d = pause;
        if (state_d == S_ERROR) begin
            pause_d = 4'hF;
        end else if ((state_d == S_RESET) || (state_d == S_INIT)) begin
            pause_d = 4'h0;
        end else if ((state_q == S_IDLE) || (state_q == S_ACTIVE)) begin
            for (int i = 0; i < 4; i++) begin
                if (occ[4*i +: 4] >= {1'b0, umbral_alto_q})
                    pause_d[i] = 1'b1;
                else if (occ[4*i +: 4] <= {1'b0, umbral_bajo_q})
                    pause_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        error_code_d = error_code;
        if (state_d == S_ERROR) begin
            if (state_q == S_ERROR) error_code_d = error_code | fifo_error;
            else                    error_code_d = fifo_error;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RESET;
            idle_out      <= 1'b0;
            active_out    <= 1'b0;
            error_out     <= 1'b0;
            umbral_bajo_q <= 3'd0;
            umbral_alto_q <= 3'd0;
            pause         <= 4'h0;
            error_code    <= 5'h00;
        end else begin
            state_q    <= state_d;
            idle_out   <= (state_d == S_IDLE);
            active_out <= (state_d == S_ACTIVE);
            error_out  <= (state_d == S_ERROR);
            pause      <= pause_d;
            error_code <= error_code_d;
            if (state_q == S_INIT) begin
                umbral_bajo_q <= Umbral_bajo;
                umbral_alto_q <= Umbral_alto;
            end
        end
    end
endmodule

// File: tb/tb_transfer_ctrl.sv
// Bench for transfer_ctrl: reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_transfer_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [2:0]  Umbral_bajo;
    logic [2:0]  Umbral_alto;
    logic [4:0]  fifo_empty;
    logic [4:0]  fifo_error;
    logic [15:0] occ;
    logic [2:0]  state;
    logic        idle_out;
    logic        active_out;
    logic        error_out;
    logic [2:0]  umbral_bajo_q;
    logic [2:0]  umbral_alto_q;
    logic [3:0]  pause;
    logic [4:0]  error_code;

    int checks   = 0;
    int failures = 0;

    transfer_ctrl dut (
        .clk(clk), .reset(reset), .init(init),
        .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error), .occ(occ),
        .state(state), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out), .umbral_bajo_q(umbral_bajo_q),
        .umbral_alto_q(umbral_alto_q), .pause(pause), .error_code(error_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as a plain number (0 reset,1 init,2 idle,3 active,4 error)
    int m_state = 0;
    int m_bajo  = 0;
    int m_alto  = 0;
    int m_err   = 0;
    bit [3:0] m_pause = 0;
    bit model_live = 0;

    always @(posedge clk) begin
        int nxt;
        bit [3:0] np;
        if (reset) begin
            m_state = 0; m_bajo = 0; m_alto = 0; m_err = 0; m_pause = 0;
        end else begin
            if (m_state == 0)      nxt = 1;
            else if (m_state == 1) nxt = (!init && Umbral_alto > Umbral_bajo) ? 2 : 1;
            else if (m_state == 4) nxt = 4;
            else if (fifo_error != 0) nxt = 4;
            else if (init)         nxt = 1;
            else                   nxt = (fifo_empty == 5'h1F) ? 2 : 3;

            np = m_pause;
            if (nxt == 4) np = 4'hF;
            else if (nxt <= 1) np = 4'h0;
            else if (m_state == 2 || m_state == 3) begin
                for (int i = 0; i < 4; i++) begin
                    int o;
                    o = int'(occ[4*i +: 4]);
                    if (o >= m_alto) np[i] = 1'b1;
                    else if (o <= m_bajo) np[i] = 1'b0;
                end
            end

            if (nxt == 4) m_err = ((m_state == 4) ? m_err : 0) | int'(fifo_error);
            if (m_state == 1) begin
                m_bajo = int'(Umbral_bajo);
                m_alto = int'(Umbral_alto);
            end
            m_pause = np;
            m_state = nxt;
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("m_state", int'(state), m_state);
            chk("m_idle", int'(idle_out), int'(m_state == 2));
            chk("m_active", int'(active_out), int'(m_state == 3));
            chk("m_error", int'(error_out), int'(m_state == 4));
            chk("m_bajo", int'(umbral_bajo_q), m_bajo);
            chk("m_alto", int'(umbral_alto_q), m_alto);
            chk("m_pause", int'(pause), int'(m_pause));
            chk("m_error_code", int'(error_code), m_err);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1; init = 0; Umbral_bajo = 0; Umbral_alto = 0;
        fifo_empty = 5'h1F; fifo_error = 0; occ = 0;
        tick(); tick();
        chk("reset_state", int'(state), 0);
        chk("reset_pause", int'(pause), 0);

        // startup
        reset = 0; init = 1; Umbral_bajo = 2; Umbral_alto = 6;
        tick(); chk("start_s1", int'(state), 1);
        tick(); chk("start_s2", int'(state), 1);
        init = 0;
        tick(); chk("start_s3", int'(state), 2);
        chk("start_idle", int'(idle_out), 1);
        chk("start_bajo", int'(umbral_bajo_q), 2);
        chk("start_alto", int'(umbral_alto_q), 6);

        // activity
        fifo_empty = 5'h1E;
        tick(); chk("act_state", int'(state), 3);
        chk("act_out", int'(active_out), 1);
        fifo_empty = 5'h1F;
        tick(); chk("idle_back", int'(state), 2);

        // hysteresis on P0
        for (int v = 0; v <= 7; v++) begin
            occ[3:0] = 4'(v);
            tick(); chk("hyst_up", int'(pause), (v >= 6) ? 1 : 0);
        end
        for (int v = 6; v >= 0; v--) begin
            occ[3:0] = 4'(v);
            tick(); chk("hyst_down", int'(pause), (v > 2) ? 1 : 0);
        end
        // occ above 8 on P3, and hold across IDLE->ACTIVE on P1
        occ[15:12] = 4'd12;
        tick(); chk("occ_big", int'(pause), 8);
        occ[15:12] = 4'd0; occ[7:4] = 4'd7;
        tick(); chk("p1_set", int'(pause), 2);
        occ[7:4] = 4'd4; fifo_empty = 5'h0F;
        tick(); chk("p1_hold_state", int'(state), 3);
        chk("p1_hold", int'(pause), 2);
        occ[7:4] = 4'd0;
        tick(); chk("p1_clear", int'(pause), 0);

        // error capture
        fifo_error = 5'b01000;
        tick(); chk("err_state", int'(state), 4);
        chk("err_pause", int'(pause), 15);
        chk("err_code1", int'(error_code), 8);
        fifo_error = 0;
        tick();
        fifo_error = 5'b00010;
        tick(); fifo_error = 0;
        tick(); chk("err_code2", int'(error_code), 10);
        chk("err_out", int'(error_out), 1);
        init = 1;
        tick(); tick(); chk("err_sticky", int'(state), 4);
        init = 0; fifo_empty = 5'h1F;
        reset = 1;
        tick(); chk("rst_state", int'(state), 0);
        chk("rst_code", int'(error_code), 0);
        chk("rst_pause", int'(pause), 0);
        tick(); chk("rst_hold_err", int'(error_out), 0);

        // bad config
        reset = 0; Umbral_bajo = 3; Umbral_alto = 3;
        tick(); chk("bad_s1", int'(state), 1);
        tick(); chk("bad_s2", int'(state), 1);
        chk("bad_pause", int'(pause), 0);
        Umbral_alto = 5;
        tick(); chk("good_state", int'(state), 2);
        chk("good_alto", int'(umbral_alto_q), 5);

        // init and error together from IDLE
        init = 1; fifo_error = 5'h01;
        tick(); chk("simul_state", int'(state), 4);
        chk("simul_code", int'(error_code), 1);
        init = 0; fifo_error = 0;
        reset = 1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
